// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
//
// Measures an asynchronous periodic signal using the system clock. It reports
// the rising-to-rising period, the rising-to-falling high time, and the phase
// offset from a reference signal's rise to the following rise of the monitored
// signal. All values are counted in clk_i cycles. A sticky flag reports a
// stopped or lost clock.
//
// Parameters
//   CNT_W    width of every measurement counter and result output
//   TIMEOUT  cycles without a monitored edge before the clock is declared lost
//            (legal range 2 .. 2^CNT_W-1)
//
// Ports
//   clk_i          system sampling clock
//   rst_i          synchronous active-high reset
//   en_i           monitor enable; low forces IDLE, results hold
//   sig_i          monitored signal (asynchronous to clk_i)
//   ref_sig_i      phase reference (asynchronous to clk_i)
//   period_o       last rising-to-rising interval
//   high_time_o    last rising-to-falling interval, reported with period_o
//   phase_o        cycles from latest ref_sig_i rise to following sig_i rise
//   meas_valid_o   one-cycle pulse when period_o/high_time_o update
//   phase_valid_o  one-cycle pulse when phase_o updates
//   locked_o       high once at least one full period has been measured
//   lost_o         sticky timeout flag, cleared by the next measurement
// -----------------------------------------------------------------------------
module clk_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  input  logic             ref_sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] phase_o,
  output logic             meas_valid_o,
  output logic             phase_valid_o,
  output logic             locked_o,
  output logic             lost_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers: two metastability flops plus one delay flop each
  // ---------------------------------------------------------------------------
  logic sig_s1_q, sig_s2_q, sig_d3_q;
  logic ref_s1_q, ref_s2_q, ref_d3_q;

  // Synchronize sig_i and ref_sig_i and keep one cycle of history for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_s1_q <= 1'b0;
      sig_s2_q <= 1'b0;
      sig_d3_q <= 1'b0;
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_d3_q <= 1'b0;
    end else begin
      sig_s1_q <= sig_i;
      sig_s2_q <= sig_s1_q;
      sig_d3_q <= sig_s2_q;
      ref_s1_q <= ref_sig_i;
      ref_s2_q <= ref_s1_q;
      ref_d3_q <= ref_s2_q;
    end
  end

  logic sig_rise_s, sig_fall_s, ref_rise_s;

  assign sig_rise_s =  sig_s2_q & ~sig_d3_q;
  assign sig_fall_s = ~sig_s2_q &  sig_d3_q;
  assign ref_rise_s =  ref_s2_q & ~ref_d3_q;

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] high_hold_q,  high_hold_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_time_q,  high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q,     locked_d;
  logic             lost_q,       lost_d;

  logic [CNT_W-1:0] ph_cnt_q,      ph_cnt_d;
  logic             ph_armed_q,    ph_armed_d;
  logic [CNT_W-1:0] phase_q,       phase_d;
  logic             phase_valid_q, phase_valid_d;

  logic             timeout_s;

  // Timeout only counts when no edge is seen this cycle: an edge always wins.
  assign timeout_s = (cnt_q == TIMEOUT_C) & ~sig_rise_s & ~sig_fall_s;

  // Next-state logic for the period/high-time FSM and its result registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_hold_d  = high_hold_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    lost_d       = lost_q;

    if (!en_i) begin
      // Results and the sticky lost flag hold; only the lock indication drops.
      state_d  = ST_IDLE;
      cnt_d    = CNT_ZERO;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_ZERO;
          state_d = ST_ARM;
        end

        ST_ARM: begin
          // The first rise only anchors the counter; it yields no measurement.
          if (sig_rise_s) begin
            cnt_d   = CNT_ONE;
            state_d = ST_HIGH;
          end else begin
            cnt_d   = CNT_ZERO;
          end
        end

        ST_HIGH: begin
          if (sig_rise_s) begin
            // A rise without a seen fall means a too-short low was missed;
            // re-anchor on this rise rather than report a bogus period.
            cnt_d = CNT_ONE;
          end else if (sig_fall_s) begin
            high_hold_d = cnt_q;
            cnt_d       = sat_inc(cnt_q);
            state_d     = ST_LOW;
          end else if (timeout_s) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            cnt_d    = CNT_ZERO;
            state_d  = ST_ARM;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end

        ST_LOW: begin
          if (sig_rise_s) begin
            // high_time is published together with period so the pair stays
            // consistent under one meas_valid pulse.
            period_d     = cnt_q;
            high_time_d  = high_hold_q;
            cnt_d        = CNT_ONE;
            meas_valid_d = 1'b1;
            locked_d     = 1'b1;
            lost_d       = 1'b0;
            state_d      = ST_HIGH;
          end else if (timeout_s) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            cnt_d    = CNT_ZERO;
            state_d  = ST_ARM;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Next-state logic for the reference-to-signal phase measurement.
  always_comb begin
    ph_cnt_d      = ph_cnt_q;
    ph_armed_d    = ph_armed_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;

    if (!en_i || (state_q == ST_IDLE)) begin
      ph_cnt_d   = CNT_ZERO;
      ph_armed_d = 1'b0;
    end else if (ref_rise_s && sig_rise_s) begin
      // Coincident edges are defined as zero phase.
      phase_d       = CNT_ZERO;
      phase_valid_d = 1'b1;
      ph_cnt_d      = CNT_ZERO;
      ph_armed_d    = 1'b0;
    end else if (ref_rise_s) begin
      ph_cnt_d   = CNT_ONE;
      ph_armed_d = 1'b1;
    end else if (ph_armed_q) begin
      if (sig_rise_s) begin
        phase_d       = ph_cnt_q;
        phase_valid_d = 1'b1;
        ph_armed_d    = 1'b0;
      end else begin
        ph_cnt_d = sat_inc(ph_cnt_q);
      end
    end else begin
      // Not armed: a sig rise leaves phase untouched.
      ph_cnt_d = ph_cnt_q;
    end
  end

  // State, counters and registered results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      high_hold_q   <= CNT_ZERO;
      period_q      <= CNT_ZERO;
      high_time_q   <= CNT_ZERO;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      ph_cnt_q      <= CNT_ZERO;
      ph_armed_q    <= 1'b0;
      phase_q       <= CNT_ZERO;
      phase_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      high_hold_q   <= high_hold_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      ph_cnt_q      <= ph_cnt_d;
      ph_armed_q    <= ph_armed_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  assign period_o      = period_q;
  assign high_time_o   = high_time_q;
  assign phase_o       = phase_q;
  assign meas_valid_o  = meas_valid_q;
  assign phase_valid_o = phase_valid_q;
  assign locked_o      = locked_q;
  assign lost_o        = lost_q;

endmodule
